// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// byte-lane select patterns, lane geometry and the alignment rule.
package dmem_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10
    } state_e;

    // Latency down-counter width (LATENCY tops out at 15)
    localparam int CNT_W = 4;

    // Byte-lane geometry: lane 3 is bits 31:24 (lowest byte address, big-endian)
    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;
    localparam int WORD_W    = NUM_LANES * LANE_W;

    // Select patterns with alignment meaning
    localparam logic [NUM_LANES-1:0] SEL_WORD = 4'b1111;
    localparam logic [NUM_LANES-1:0] SEL_HI   = 4'b1100;
    localparam logic [NUM_LANES-1:0] SEL_LO   = 4'b0011;

    // Lowest bit index of a byte lane inside the 32-bit word
    function automatic int lane_lsb(input int lane);
        return lane * LANE_W;
    endfunction

    // Word access needs a word-aligned address; halfword access needs an
    // even address. Single-byte and irregular selects are never flagged.
    function automatic logic is_misaligned(input logic [NUM_LANES-1:0] sel,
                                           input logic [1:0]           addr_lo);
        logic word_bad;
        logic half_bad;
        word_bad = (sel == SEL_WORD) && (addr_lo != 2'b00);
        half_bad = ((sel == SEL_HI) || (sel == SEL_LO)) && addr_lo[0];
        return word_bad || half_bad;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the
// data-memory responder (slave). resp_err exists only when
// DMEM_ALIGN_CHECK_EN is defined.
interface dmem_responder_if;

    logic        req_ce;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_sel;
    logic [31:0] req_wdata;

    logic        resp_ack;
    logic [31:0] resp_rdata;
    logic        busy;

`ifdef DMEM_ALIGN_CHECK_EN
    logic        resp_err;

    modport master (
        output req_ce, req_we, req_addr, req_sel, req_wdata,
        input  resp_ack, resp_rdata, busy, resp_err
    );

    modport slave (
        input  req_ce, req_we, req_addr, req_sel, req_wdata,
        output resp_ack, resp_rdata, busy, resp_err
    );
`else
    modport master (
        output req_ce, req_we, req_addr, req_sel, req_wdata,
        input  resp_ack, resp_rdata, busy
    );

    modport slave (
        input  req_ce, req_we, req_addr, req_sel, req_wdata,
        output resp_ack, resp_rdata, busy
    );
`endif

endinterface

// File: rtl/dmem_ram_array.sv
// Single-port word array with a write enable per byte lane and a
// combinational read of the addressed word. Each lane is its own byte
// array so every storage element has exactly one writer.
module dmem_ram_array
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                 clk,
    input  logic [NUM_LANES-1:0] we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WORD_W-1:0]    wdata_i,
    output logic [WORD_W-1:0]    rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [LANE_W-1:0] lane_mem [DEPTH];

            // Byte-lane write, only when this lane is enabled
            always_ff @(posedge clk) begin
                if (we_i[gi]) begin
                    lane_mem[addr_i] <= wdata_i[lane_lsb(gi) +: LANE_W];
                end
            end

            assign rdata_o[lane_lsb(gi) +: LANE_W] = lane_mem[addr_i];
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts a held MEM-stage request, waits LATENCY
// cycles, performs a byte-lane store or full-word load and pulses resp_ack.
// Optional feature: define DMEM_ALIGN_CHECK_EN to add resp_err and
// suppress misaligned accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $fatal(1, "dmem_responder: LATENCY=%0d outside 1..15", LATENCY);
        end
        if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_bad_addr_width
            $fatal(1, "dmem_responder: ADDR_WIDTH=%0d outside 1..29", ADDR_WIDTH);
        end
    endgenerate

    state_e                state_q;
    state_e                state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [WORD_W-1:0]     rdata_q;
    logic [WORD_W-1:0]     rdata_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [NUM_LANES-1:0]  sel_q;
    logic [WORD_W-1:0]     wdata_q;

    logic                  accept;
    logic                  acc_err;
    logic                  ack;
    logic [WORD_W-1:0]     rdata_out;
    logic [NUM_LANES-1:0]  ram_we;
    logic [WORD_W-1:0]     ram_rdata;

    // Address bits outside the word index only matter to the alignment check
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.req_addr[31:ADDR_WIDTH+2], bus.req_addr[1:0]};

    assign accept = (state_q == ST_IDLE) && bus.req_ce;

    // Snapshot the request on acceptance; the copy drives the whole access
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.req_addr[ADDR_WIDTH+1:2];
            we_q    <= bus.req_we;
            sel_q   <= bus.req_sel;
            wdata_q <= bus.req_wdata;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic mis_q;

    // Alignment verdict taken together with the request snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else if (accept) begin
            mis_q <= is_misaligned(bus.req_sel, bus.req_addr[1:0]);
        end
    end

    assign acc_err = mis_q;
`else
    assign acc_err = 1'b0;
`endif

    // State register, latency counter and held load data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state: IDLE accepts, WAIT counts down, ACK always returns to IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_ce) begin
                    if (LATENCY == 1) begin
                        state_d = ST_ACK;
                    end else begin
                        cnt_d   = CNT_W'(LATENCY - 2);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: the ACK cycle performs the access; read data is held afterwards.
    // A reset landing in the ACK cycle suppresses the write.
    always_comb begin
        ack       = (state_q == ST_ACK);
        rdata_out = rdata_q;
        rdata_d   = rdata_q;
        ram_we    = '0;
        if (ack) begin
            if (we_q) begin
                rdata_out = '0;
                if (!acc_err && !rst) begin
                    ram_we = sel_q;
                end
            end else begin
                rdata_out = acc_err ? '0 : ram_rdata;
            end
            rdata_d = rdata_out;
        end
    end

    assign bus.resp_ack   = ack;
    assign bus.resp_rdata = rdata_out;
    assign bus.busy       = (state_q != ST_IDLE);
`ifdef DMEM_ALIGN_CHECK_EN
    assign bus.resp_err   = ack && acc_err;
`endif

    dmem_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance at LATENCY=2 and one at LATENCY=1,
// each checked every cycle against a transaction-level memory model.
module tb_dmem_responder;

    localparam int NI   = 2;
    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic        drv_ce    [NI];
    logic        drv_we    [NI];
    logic [31:0] drv_addr  [NI];
    logic [3:0]  drv_sel   [NI];
    logic [31:0] drv_wdata [NI];

    logic        mon_ack   [NI];
    logic        mon_busy  [NI];
    logic        mon_err   [NI];
    logic [31:0] mon_rdata [NI];

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    assign bus0.req_ce    = drv_ce[0];
    assign bus0.req_we    = drv_we[0];
    assign bus0.req_addr  = drv_addr[0];
    assign bus0.req_sel   = drv_sel[0];
    assign bus0.req_wdata = drv_wdata[0];
    assign bus1.req_ce    = drv_ce[1];
    assign bus1.req_we    = drv_we[1];
    assign bus1.req_addr  = drv_addr[1];
    assign bus1.req_sel   = drv_sel[1];
    assign bus1.req_wdata = drv_wdata[1];

    assign mon_ack[0]   = bus0.resp_ack;
    assign mon_busy[0]  = bus0.busy;
    assign mon_rdata[0] = bus0.resp_rdata;
    assign mon_ack[1]   = bus1.resp_ack;
    assign mon_busy[1]  = bus1.busy;
    assign mon_rdata[1] = bus1.resp_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
    assign mon_err[0] = bus0.resp_err;
    assign mon_err[1] = bus1.resp_err;
`else
    assign mon_err[0] = 1'b0;
    assign mon_err[1] = 1'b0;
`endif

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT0)) u_dut_l2 (.clk(clk), .rst(rst), .bus(bus0));
    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT1)) u_dut_l1 (.clk(clk), .rst(rst), .bus(bus1));

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem     [NI][1024];
    bit          m_known_w [NI][1024];
    bit          m_valid   [NI];
    bit          m_ack     [NI];
    bit          m_busy    [NI];
    bit          m_err     [NI];
    bit          m_rd_known[NI];
    logic [31:0] m_rdata   [NI];
    int          m_ack_at  [NI];
    bit          c_we      [NI];
    bit          c_mis     [NI];
    int          c_word    [NI];
    logic [3:0]  c_sel     [NI];
    logic [31:0] c_wdata   [NI];

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr / 4) % 1024);
    endfunction

`ifdef DMEM_ALIGN_CHECK_EN
    function automatic bit misaligned(input logic [31:0] addr, input logic [3:0] sel);
        if (sel == 4'b1111) return (addr % 4) != 0;
        if (sel == 4'b1100 || sel == 4'b0011) return (addr % 2) != 0;
        return 1'b0;
    endfunction
`endif

    // Byte at address offset j of a big-endian word sits in bits 31-8j..24-8j, enabled by sel[3-j]
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int j = 0; j < 4; j++) begin
            if (sel[3-j]) r[31-8*j -: 8] = nw[31-8*j -: 8];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Predict the outputs that will be visible after the coming rising edge
    task automatic model_step(input int k);
        int e;
        e = cyc + 1;
        if (rst) begin
            m_valid[k]    = 1'b1;
            m_ack[k]      = 1'b0;
            m_busy[k]     = 1'b0;
            m_err[k]      = 1'b0;
            m_rdata[k]    = '0;
            m_rd_known[k] = 1'b1;
        end else if (m_ack[k]) begin
            if (c_we[k] && !c_mis[k]) begin
                m_mem[k][c_word[k]]     = merge(m_mem[k][c_word[k]], c_wdata[k], c_sel[k]);
                m_known_w[k][c_word[k]] = 1'b1;
            end
            m_ack[k]  = 1'b0;
            m_busy[k] = 1'b0;
            m_err[k]  = 1'b0;
        end else begin
            if (!m_busy[k] && drv_ce[k] === 1'b1) begin
                c_we[k]    = drv_we[k];
                c_word[k]  = word_of(drv_addr[k]);
                c_sel[k]   = drv_sel[k];
                c_wdata[k] = drv_wdata[k];
`ifdef DMEM_ALIGN_CHECK_EN
                c_mis[k]   = misaligned(drv_addr[k], drv_sel[k]);
`else
                c_mis[k]   = 1'b0;
`endif
                m_busy[k]   = 1'b1;
                m_ack_at[k] = e + lat_of(k) - 1;
            end
            if (m_busy[k] && e == m_ack_at[k]) begin
                m_ack[k] = 1'b1;
                m_err[k] = c_mis[k];
                if (c_we[k] || c_mis[k]) begin
                    m_rdata[k]    = '0;
                    m_rd_known[k] = 1'b1;
                end else begin
                    m_rdata[k]    = m_mem[k][c_word[k]];
                    m_rd_known[k] = m_known_w[k][c_word[k]];
                end
            end
        end
    endtask

    // Every-cycle compare against the model, then advance the model
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (m_valid[k]) begin
                chk($sformatf("i%0d_ack", k),  {31'd0, mon_ack[k]},  {31'd0, m_ack[k]});
                chk($sformatf("i%0d_busy", k), {31'd0, mon_busy[k]}, {31'd0, m_busy[k]});
                if (m_rd_known[k]) chk($sformatf("i%0d_rdata", k), mon_rdata[k], m_rdata[k]);
`ifdef DMEM_ALIGN_CHECK_EN
                chk($sformatf("i%0d_err", k), {31'd0, mon_err[k]}, {31'd0, m_err[k]});
`endif
            end
            model_step(k);
        end
    end

    // ---------------- driver ----------------
    // Called #1 after a rising edge with the DUT idle; returns #1 after the edge ending ACK.
    task automatic issue(input int k, input bit we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] wd, input bit scramble,
                         output logic [31:0] rd, output bit er, output int lat, output int ack_cyc);
        int t;
        drv_ce[k]    = 1'b1;
        drv_we[k]    = we;
        drv_addr[k]  = addr;
        drv_sel[k]   = sel;
        drv_wdata[k] = wd;
        @(posedge clk); #1;
        if (scramble) begin
            drv_we[k]    = 1'($urandom);
            drv_addr[k]  = $urandom;
            drv_sel[k]   = 4'($urandom);
            drv_wdata[k] = $urandom;
        end
        rd = '0; er = 1'b0; lat = 0; ack_cyc = -1;
        t = 0;
        while (t < 40) begin
            @(negedge clk);
            t++;
            if (mon_ack[k] === 1'b1) break;
        end
        if (mon_ack[k] !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL i%0d_ack_timeout: got no ack, required ack within 40 cycles", k);
        end else begin
            rd      = mon_rdata[k];
            er      = mon_err[k];
            lat     = t;
            ack_cyc = cyc;
        end
        @(posedge clk); #1;
        drv_ce[k] = 1'b0;
    endtask

    logic [31:0] pool [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before 2ms");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        bit          er;
        int          lt;
        int          ac;
        int          ac1;
        int          acks;
        logic [31:0] a;
        logic [3:0]  s;

        for (int k = 0; k < NI; k++) begin
            drv_ce[k] = 1'b0; drv_we[k] = 1'b0; drv_addr[k] = '0; drv_sel[k] = '0; drv_wdata[k] = '0;
        end
        pool[0] = 32'h0000_0000; pool[1] = 32'h0000_0010; pool[2] = 32'h0000_0040; pool[3] = 32'h0000_0080;
        pool[4] = 32'h0000_0084; pool[5] = 32'h0000_0200; pool[6] = 32'h0000_03FC; pool[7] = 32'h1000_0040;

        // Pin the model's big-endian lane merge
        chk("model_merge", merge(32'h11223344, 32'h00AA0000, 4'b0100), 32'h11AA3344);
        chk("model_merge_hi", merge(32'h11223344, 32'hABCD0000, 4'b1100), 32'hABCD3344);

        // Reset for two cycles, then ten idle cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ack",   {31'd0, mon_ack[0]},  32'd0);
            chk("idle_busy",  {31'd0, mon_busy[0]}, 32'd0);
            chk("idle_rdata", mon_rdata[0],         32'd0);
        end
        @(posedge clk); #1;

        // Preload every pool word on both instances
        for (int k = 0; k < NI; k++) begin
            for (int p = 0; p < 8; p++) begin
                issue(k, 1'b1, pool[p], 4'b1111, $urandom, 1'b0, rd, er, lt, ac);
            end
        end

        // Word store/load at LATENCY=2
        issue(0, 1'b1, 32'h40, 4'b1111, 32'hDEADBEEF, 1'b0, rd, er, lt, ac);
        chk("store_latency", lt, 2);
        chk("store_rdata", rd, 32'h0);
        issue(0, 1'b0, 32'h40, 4'b0001, 32'h0, 1'b0, rd, er, lt, ac);
        chk("load_latency", lt, 2);
        chk("load_word", rd, 32'hDEADBEEF);

        // Byte-lane write
        issue(0, 1'b1, 32'h80, 4'b1111, 32'h11223344, 1'b0, rd, er, lt, ac);
        issue(0, 1'b1, 32'h80, 4'b0100, 32'h00AA0000, 1'b0, rd, er, lt, ac);
        issue(0, 1'b0, 32'h80, 4'b1111, 32'h0, 1'b0, rd, er, lt, ac);
        chk("byte_lane", rd, 32'h11AA3344);

        // Store with no lanes selected, then an aliased address
        issue(0, 1'b1, 32'h40, 4'b0000, 32'hFFFFFFFF, 1'b0, rd, er, lt, ac);
        issue(0, 1'b0, 32'h1000_0040, 4'b1111, 32'h0, 1'b0, rd, er, lt, ac);
        chk("sel0_alias", rd, 32'hDEADBEEF);

        // Reset in the WAIT cycle aborts the store
        issue(0, 1'b1, 32'h10, 4'b1111, 32'hCAFEF00D, 1'b0, rd, er, lt, ac);
        drv_ce[0] = 1'b1; drv_we[0] = 1'b1; drv_addr[0] = 32'h10; drv_sel[0] = 4'b1111; drv_wdata[0] = 32'h12345678;
        @(posedge clk); #1;
        rst = 1'b1;
        drv_ce[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mon_ack[0] === 1'b1) acks++;
        end
        chk("rst_abort_acks", acks, 0);
        @(posedge clk); #1;
        issue(0, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, rd, er, lt, ac);
        chk("rst_abort_mem", rd, 32'hCAFEF00D);

`ifdef DMEM_ALIGN_CHECK_EN
        // Misaligned word store is suppressed; halfword load at even address is fine
        issue(0, 1'b1, 32'h42, 4'b1111, 32'h55555555, 1'b0, rd, er, lt, ac);
        chk("mis_store_err", {31'd0, er}, 32'd1);
        chk("mis_store_lat", lt, 2);
        issue(0, 1'b0, 32'h40, 4'b1111, 32'h0, 1'b0, rd, er, lt, ac);
        chk("mis_store_mem", rd, 32'hDEADBEEF);
        chk("aligned_err", {31'd0, er}, 32'd0);
        issue(0, 1'b0, 32'h42, 4'b0011, 32'h0, 1'b0, rd, er, lt, ac);
        chk("half_load_err", {31'd0, er}, 32'd0);
        chk("half_load_data", rd, 32'hDEADBEEF);
`endif

        // LATENCY=1 back-to-back loads
        issue(1, 1'b1, 32'h40, 4'b1111, 32'hA5A50F0F, 1'b0, rd, er, lt, ac);
        issue(1, 1'b0, 32'h40, 4'b1111, 32'h0, 1'b0, rd, er, lt, ac1);
        chk("l1_lat_a", lt, 1);
        chk("l1_data_a", rd, 32'hA5A50F0F);
        issue(1, 1'b0, 32'h40, 4'b1111, 32'h0, 1'b0, rd, er, lt, ac);
        chk("l1_lat_b", lt, 1);
        chk("l1_ack_spacing", ac - ac1, 2);

        // Randomised traffic on both instances
        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 150; n++) begin
                a = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0:       s = 4'b1111;
                    1:       s = 4'b1100;
                    2:       s = 4'b0011;
                    default: s = 4'($urandom);
                endcase
                issue(k, 1'($urandom), a, s, $urandom, ($urandom_range(0, 3) == 0), rd, er, lt, ac);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
